// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared types and constants for the MAC pin sequencer
//
// Purpose : sequencer state encoding, default timing widths and the one-hot
//           strobe codes {mac_ld, mac_ld4, mac_ld3, mac_ld2, mac_ld1}.
// Ports   : none (package).
package mac_seq_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_CLR,
      ST_LD1,
      ST_LD2,
      ST_LD3,
      ST_LD4,
      ST_FIRE,
      ST_WAIT,
      ST_RESP
   } state_t;

   localparam int DEF_RESULT_LATENCY = 2;
   localparam int DEF_RST_PULSE      = 2;

   localparam logic [4:0] STB_NONE = 5'b00000;
   localparam logic [4:0] STB_LD1  = 5'b00001;
   localparam logic [4:0] STB_LD2  = 5'b00010;
   localparam logic [4:0] STB_LD3  = 5'b00100;
   localparam logic [4:0] STB_LD4  = 5'b01000;
   localparam logic [4:0] STB_FIRE = 5'b10000;

   // States that drive exactly one MAC strobe (and may get a setup cycle).
   function automatic logic is_strobe_state(input state_t s);
      return (s == ST_LD1) || (s == ST_LD2) || (s == ST_LD3) ||
             (s == ST_LD4) || (s == ST_FIRE);
   endfunction

   function automatic logic [4:0] strobe_of(input state_t s);
      logic [4:0] stb;
      case (s)
         ST_LD1:  stb = STB_LD1;
         ST_LD2:  stb = STB_LD2;
         ST_LD3:  stb = STB_LD3;
         ST_LD4:  stb = STB_LD4;
         ST_FIRE: stb = STB_FIRE;
         default: stb = STB_NONE;
      endcase
      return stb;
   endfunction

endpackage

// File: rtl/mac_seq_wait_ctr.sv
// rtl/mac_seq_wait_ctr.sv - 4-bit loadable down-counter with zero flag
//
// Purpose : times both the result-latency wait and the mac_rst pulse.
// Ports   : clk, rst_n (async, active-low), load / load_val (load wins over
//           dec), dec (count down, saturating at 0), zero (count == 0).
module mac_seq_wait_ctr (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [3:0] load_val,
   input  logic       dec,
   output logic       zero
);

   logic [3:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= 4'd0;
      end else if (load) begin
         count <= load_val;
      end else if (dec && (count != 4'd0)) begin
         count <= count - 4'd1;
      end
   end

   assign zero = (count == 4'd0);

endmodule

// File: rtl/mac_pin_sequencer.sv
// rtl/mac_pin_sequencer.sv - command-driven pin sequencer for the MAC accelerator
//
// Purpose : accepts an operand command, walks the MAC through ld1..ld4/ld,
//           waits RESULT_LATENCY cycles, captures mac_out and returns it.
// Ports   : clk, rst_n (async, active-low)
//           cmd_valid/cmd_ready, cmd_a, cmd_b, cmd_acc, cmd_load_acc, clr
//           rsp_valid/rsp_ready, rsp_data, busy
//           mac_in, mac_ld1..mac_ld4, mac_ld, mac_clken, mac_rst, mac_out
// Option  : MAC_SEQ_SETUP_EN - one setup cycle (byte driven, no strobe)
//           before every strobe cycle.
module mac_pin_sequencer
   import mac_seq_pkg::*;
#(
   parameter int RESULT_LATENCY = DEF_RESULT_LATENCY,
   parameter int RST_PULSE      = DEF_RST_PULSE
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [7:0]  cmd_a,
   input  logic [7:0]  cmd_b,
   input  logic [15:0] cmd_acc,
   input  logic        cmd_load_acc,
   input  logic        clr,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_data,
   output logic        busy,
   output logic [7:0]  mac_in,
   output logic        mac_ld1,
   output logic        mac_ld2,
   output logic        mac_ld3,
   output logic        mac_ld4,
   output logic        mac_ld,
   output logic        mac_clken,
   output logic        mac_rst,
   input  logic [15:0] mac_out
);

`ifdef MAC_SEQ_SETUP_EN
   localparam logic SETUP_EN = 1'b1;
`else
   localparam logic SETUP_EN = 1'b0;
`endif

   localparam logic [3:0] LAT_VAL = 4'(RESULT_LATENCY - 1);
   localparam logic [3:0] RST_VAL = 4'(RST_PULSE - 1);

   state_t      state, state_nx, adv;
   logic        setup_q, setup_nx;
   logic        rst_done;
   logic [7:0]  a_q, b_q;
   logic [15:0] acc_q;
   logic        load_acc_q;
   logic        cnt_load, cnt_dec, cnt_zero;
   logic [3:0]  cnt_val;
   logic [4:0]  stb_nx;
   logic [7:0]  byte_nx;
   logic        clken_nx;

   // rst_done keeps cmd_ready low while reset is held and releases it one
   // edge later, even though the state register already sits in IDLE.
   assign cmd_ready = (state == ST_IDLE) && rst_done;

   always_comb begin
      adv = state;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) adv = ST_LD1;
            else if (clr && rst_done)   adv = ST_CLR;
         end
         ST_CLR:  if (cnt_zero) adv = ST_IDLE;
         ST_LD1:  adv = ST_LD2;
         ST_LD2:  adv = load_acc_q ? ST_LD3 : ST_FIRE;
         ST_LD3:  adv = ST_LD4;
         ST_LD4:  adv = ST_FIRE;
         ST_FIRE: adv = ST_WAIT;
         ST_WAIT: if (cnt_zero) adv = ST_RESP;
         ST_RESP: if (rsp_ready) adv = ST_IDLE;
         default: adv = ST_IDLE;
      endcase

      // A setup cycle holds the state for one extra cycle; every strobe
      // state is entered fresh, so state_nx != state marks the setup cycle.
      state_nx = (SETUP_EN && setup_q) ? state : adv;
      setup_nx = SETUP_EN && is_strobe_state(state_nx) && (state_nx != state);

      cnt_load = ((state == ST_IDLE) && (state_nx == ST_CLR)) ||
                 ((state == ST_FIRE) && (state_nx == ST_WAIT));
      cnt_val  = (state == ST_FIRE) ? LAT_VAL : RST_VAL;
      cnt_dec  = (state == ST_WAIT) || (state == ST_CLR);

      // LD1 is the only strobe state entered from IDLE, where the operands
      // are not yet latched.
      case (state_nx)
         ST_LD1:  byte_nx = (state == ST_IDLE) ? cmd_a : a_q;
         ST_LD2:  byte_nx = b_q;
         ST_LD3:  byte_nx = acc_q[7:0];
         ST_LD4:  byte_nx = acc_q[15:8];
         default: byte_nx = 8'h00;
      endcase

      stb_nx   = setup_nx ? STB_NONE : strobe_of(state_nx);
      clken_nx = is_strobe_state(state_nx) || (state_nx == ST_WAIT);
   end

   mac_seq_wait_ctr u_wait_ctr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (cnt_load),
      .load_val (cnt_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   // Outputs are registered from the next-state decode so the pins change
   // on the same edge as the state they belong to.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= ST_IDLE;
         setup_q    <= 1'b0;
         rst_done   <= 1'b0;
         a_q        <= 8'h00;
         b_q        <= 8'h00;
         acc_q      <= 16'h0000;
         load_acc_q <= 1'b0;
         {mac_ld, mac_ld4, mac_ld3, mac_ld2, mac_ld1} <= STB_NONE;
         mac_in     <= 8'h00;
         mac_clken  <= 1'b0;
         mac_rst    <= 1'b0;
         busy       <= 1'b0;
         rsp_valid  <= 1'b0;
         rsp_data   <= 16'h0000;
      end else begin
         state    <= state_nx;
         setup_q  <= setup_nx;
         rst_done <= 1'b1;
         if ((state == ST_IDLE) && cmd_valid && cmd_ready) begin
            a_q        <= cmd_a;
            b_q        <= cmd_b;
            acc_q      <= cmd_acc;
            load_acc_q <= cmd_load_acc;
         end
         {mac_ld, mac_ld4, mac_ld3, mac_ld2, mac_ld1} <= stb_nx;
         mac_in    <= byte_nx;
         mac_clken <= clken_nx;
         mac_rst   <= (state_nx == ST_CLR);
         busy      <= (state_nx != ST_IDLE);
         rsp_valid <= (state_nx == ST_RESP);
         if ((state == ST_WAIT) && cnt_zero) rsp_data <= mac_out;
      end
   end

endmodule

// File: tb/tb_mac_pin_sequencer.sv
// tb/tb_mac_pin_sequencer.sv - self-checking bench for mac_pin_sequencer
module tb_mac_pin_sequencer;

   localparam int L  = 2;
   localparam int RP = 2;
`ifdef MAC_SEQ_SETUP_EN
   localparam bit SETUP = 1'b1;
`else
   localparam bit SETUP = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid, cmd_ready, cmd_load_acc, clr;
   logic [7:0]  cmd_a, cmd_b;
   logic [15:0] cmd_acc;
   logic        rsp_valid, rsp_ready, busy;
   logic [15:0] rsp_data;
   logic [7:0]  mac_in;
   logic        mac_ld1, mac_ld2, mac_ld3, mac_ld4, mac_ld, mac_clken, mac_rst;
   logic [15:0] mac_out;
   logic [4:0]  stb;

   assign stb = {mac_ld, mac_ld4, mac_ld3, mac_ld2, mac_ld1};

   always #5 clk = ~clk;

   mac_pin_sequencer #(.RESULT_LATENCY(L), .RST_PULSE(RP)) dut (
      .clk(clk), .rst_n(rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_acc(cmd_acc),
      .cmd_load_acc(cmd_load_acc), .clr(clr),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .busy(busy), .mac_in(mac_in),
      .mac_ld1(mac_ld1), .mac_ld2(mac_ld2), .mac_ld3(mac_ld3),
      .mac_ld4(mac_ld4), .mac_ld(mac_ld),
      .mac_clken(mac_clken), .mac_rst(mac_rst), .mac_out(mac_out)
   );

   // Behavioural MAC: registers load on strobes, ld accumulates a*b, result
   // appears on mac_out L cycles after the ld cycle.
   logic [7:0]  m_a = 8'h00, m_b = 8'h00;
   logic [15:0] m_acc = 16'h0000;
   logic [15:0] m_dly [1:15];

   initial for (int i = 1; i < 16; i++) m_dly[i] = 16'h0000;

   always @(posedge clk) begin
      if (mac_rst) begin
         m_a <= 8'h00; m_b <= 8'h00; m_acc <= 16'h0000;
      end else if (mac_clken) begin
         if (mac_ld1) m_a <= mac_in;
         if (mac_ld2) m_b <= mac_in;
         if (mac_ld3) m_acc[7:0]  <= mac_in;
         if (mac_ld4) m_acc[15:8] <= mac_in;
         if (mac_ld)  m_acc <= m_acc + 16'(m_a) * 16'(m_b);
      end
      m_dly[1] <= m_acc;
      for (int i = 2; i < 16; i++) m_dly[i] <= m_dly[i-1];
   end

   assign mac_out = m_dly[L-1];

   int checks = 0;
   int errors = 0;
   int mac_rst_cycles = 0;
   logic [15:0] sb_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         check("one_strobe", {31'b0, ($countones(stb) <= 1)}, 32'd1);
         if (!SETUP && stb == 5'b0) check("idle_bus_zero", {24'b0, mac_in}, 32'd0);
         if (rsp_valid || mac_rst) check("clken_off", {31'b0, mac_clken}, 32'd0);
         if (mac_rst) mac_rst_cycles++;
         if (rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) check("sb_unexpected_rsp", 32'd1, 32'd0);
            else check("sb_rsp_data", {16'b0, rsp_data}, {16'b0, sb_q.pop_front()});
         end
      end
   end

   task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [15:0] acc,
                          input logic la, input logic [15:0] exp, input logic with_clr);
      logic [12:0] seq [$];
      int k, lat;
      bit seen;
      seq = {};
      if (SETUP) seq.push_back({5'b00000, a});
      seq.push_back({5'b00001, a});
      if (SETUP) seq.push_back({5'b00000, b});
      seq.push_back({5'b00010, b});
      if (la) begin
         if (SETUP) seq.push_back({5'b00000, acc[7:0]});
         seq.push_back({5'b00100, acc[7:0]});
         if (SETUP) seq.push_back({5'b00000, acc[15:8]});
         seq.push_back({5'b01000, acc[15:8]});
      end
      if (SETUP) seq.push_back({5'b00000, 8'h00});
      seq.push_back({5'b10000, 8'h00});
      lat = (la ? 6 : 4) + L + (SETUP ? (la ? 5 : 3) : 0);

      cmd_a = a; cmd_b = b; cmd_acc = acc; cmd_load_acc = la;
      cmd_valid = 1'b1; clr = with_clr;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = cmd_ready;
      end
      check("cmd_accept", {31'b0, seen}, 32'd1);
      @(posedge clk); #1;
      cmd_valid = 1'b0; clr = 1'b0;
      sb_q.push_back(exp);
      for (int i = 0; i < seq.size(); i++) begin
         @(negedge clk);
         check($sformatf("pins_cycle%0d", i + 1), {19'b0, stb, mac_in}, {19'b0, seq[i]});
      end
      k = seq.size();
      seen = 1'b0;
      while (!seen && k < 60) begin
         @(negedge clk);
         k++;
         seen = rsp_valid;
         if (!seen) check("wait_quiet", {26'b0, mac_clken, stb}, {26'b0, 1'b1, 5'b0});
      end
      check("rsp_latency", k, lat);
   endtask

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] acc;
      logic        la;
      logic [15:0] exp;
   } vec_t;

   vec_t vecs [5];
   int   n0, n_rv;
   bit   seen;

   initial begin
      vecs[0] = '{8'h03, 8'h05, 16'h0010, 1'b1, 16'h001F};
      vecs[1] = '{8'h02, 8'h04, 16'hDEAD, 1'b0, 16'h0027};
      vecs[2] = '{8'h10, 8'h10, 16'h0000, 1'b1, 16'h0100};
      vecs[3] = '{8'h01, 8'h01, 16'hBEEF, 1'b0, 16'h0101};
      vecs[4] = '{8'h7F, 8'h02, 16'h1234, 1'b1, 16'h1332};

      rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = 8'h00; cmd_b = 8'h00;
      cmd_acc = 16'h0000; cmd_load_acc = 1'b0; clr = 1'b0; rsp_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("rst_outputs", {13'b0, stb, mac_in, mac_clken, mac_rst, rsp_valid, busy, cmd_ready}, 32'd0);
      check("rst_rsp_data", {16'b0, rsp_data}, 32'd0);
      rst_n = 1'b1;
      #1 check("ready_low_before_edge", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
      check("ready_after_rst", {31'b0, cmd_ready}, 32'd1);
      @(posedge clk); #1;

      for (int v = 0; v < 5; v++) begin
         run_cmd(vecs[v].a, vecs[v].b, vecs[v].acc, vecs[v].la, vecs[v].exp, 1'b0);
         @(negedge clk);
         check("ready_after_handshake", {30'b0, cmd_ready, rsp_valid}, 32'd2);
         @(posedge clk); #1;
      end

      // backpressure
      rsp_ready = 1'b0;
      run_cmd(8'h03, 8'h03, 16'h0000, 1'b0, 16'h133B, 1'b0);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_hold", {23'b0, rsp_valid, cmd_ready, mac_clken, stb, busy}, {23'b0, 1'b1, 1'b0, 1'b0, 5'b0, 1'b1});
         check("bp_data", {16'b0, rsp_data}, 32'h133B);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      @(negedge clk);
      check("bp_ready_back", {31'b0, cmd_ready}, 32'd1);
      @(posedge clk); #1;

      // clear pulse
      n0 = mac_rst_cycles;
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      @(negedge clk);
      check("clr_busy", {29'b0, busy, mac_rst, cmd_ready}, 32'd6);
      repeat (6) @(negedge clk);
      check("clr_pulse_len", mac_rst_cycles - n0, RP);
      @(posedge clk); #1;
      run_cmd(8'hFF, 8'hFF, 16'h0000, 1'b0, 16'hFE01, 1'b0);
      @(posedge clk); #1;

      // reset in LD3
      cmd_a = 8'h11; cmd_b = 8'h22; cmd_acc = 16'h3344; cmd_load_acc = 1'b1;
      cmd_valid = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 50 && !seen; i++) begin
         @(negedge clk);
         seen = cmd_ready;
      end
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = mac_ld3;
      end
      check("saw_ld3", {31'b0, seen}, 32'd1);
      rst_n = 1'b0;
      #1 check("rst_midop_pins", {14'b0, stb, mac_in, mac_clken, mac_rst, busy, rsp_valid}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_midop_rst", {31'b0, cmd_ready}, 32'd1);
      n_rv = 0;
      repeat (20) begin
         @(negedge clk);
         if (rsp_valid) n_rv++;
      end
      check("no_stale_rsp", n_rv, 0);
      @(posedge clk); #1;

      // cmd_valid wins over a simultaneous clr
      n0 = mac_rst_cycles;
      run_cmd(8'h02, 8'h03, 16'h0005, 1'b1, 16'h000B, 1'b1);
      @(posedge clk); #1;
      repeat (4) @(negedge clk);
      check("clr_dropped", mac_rst_cycles - n0, 0);
      check("sb_empty", sb_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
